exe_stage_md: RTL and testbench

- Parametrised execute stage for the in-order pipeline.
- Adds an iterative RV32M/RV64M multiply/divide unit beside the single-cycle ALU.
- Uses the valid/allow_in handshake: ID → EXE → MEM.
- A mul/div op holds the stage (ready_go low) until the iterative unit finishes. The result then waits until MEM accepts it.

---
 rtl/exe_stage_md.sv | 197 +++++++++++++++++++
 tb/tb_exe_stage_md.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_md.sv
// Execute stage: single-cycle ALU beside an iterative RV32M/RV64M multiply/divide unit.
// Optional build macro EXE_MD_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module exe_stage_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_to_exe_valid,
  output logic             exe_allow_in,
  input  logic             mem_allow_in,
  output logic             exe_to_mem_valid,
  input  logic             flush,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [3:0]       in_alu_op,
  input  logic             in_md_en,
  input  logic [2:0]       in_md_op,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             exe_busy,
  output logic             exe_fwd_valid
);

  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] v, input logic neg);
    fix_sign = neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] fix_sign_wide(input logic [2*XLEN-1:0] v, input logic neg);
    fix_sign_wide = neg ? -v : v;
  endfunction

  logic              exe_valid;
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   pc_r, src1_r, src2_r;
  logic [3:0]        alu_op_r;
  logic              md_en_r;
  logic [2:0]        md_op_r;
  logic [4:0]        rd_r;
  logic              wen_r;

  logic [2*XLEN-1:0] prod_r, mcand_r;
  logic [XLEN-1:0]   mplier_r, md_res_r;
  logic              neg_r;

  logic              ready_go, launch, is_div, is_rem, div_zero;
  logic              s1_neg, s2_neg, launch_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] mul_sum, prod_fix;
  logic [XLEN-1:0]   mplier_sh, mul_res, rem_nxt, quo_nxt;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              q_bit, last_iter, mul_done, iter_done;
  logic [XLEN-1:0]   alu_res;
  logic signed [XLEN-1:0] src1_s, src2_s;
  logic [SH_W-1:0]   shamt;

  assign ready_go         = !md_en_r || (state == DONE);
  assign exe_allow_in     = !exe_valid || (ready_go && mem_allow_in);
  assign exe_to_mem_valid = exe_valid && ready_go;
  assign exe_busy         = exe_valid && md_en_r && (state != DONE);
  assign exe_fwd_valid    = exe_valid && ready_go && wen_r;

  assign out_pc     = exe_valid ? pc_r : '0;
  assign out_result = exe_valid ? (md_en_r ? md_res_r : alu_res) : '0;
  assign out_rd     = exe_valid ? rd_r : '0;
  assign out_wen    = exe_valid && wen_r;

  // ALU: combinational result from the captured operands
  assign src1_s = src1_r;
  assign src2_s = src2_r;
  assign shamt  = src2_r[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_r)
      4'd0:    alu_res = src1_r + src2_r;
      4'd1:    alu_res = src1_r - src2_r;
      4'd2:    alu_res = src1_r << shamt;
      4'd3:    alu_res[0] = src1_s < src2_s;
      4'd4:    alu_res[0] = src1_r < src2_r;
      4'd5:    alu_res = src1_r ^ src2_r;
      4'd6:    alu_res = src1_r >> shamt;
      4'd7:    alu_res = src1_s >>> shamt;
      4'd8:    alu_res = src1_r | src2_r;
      4'd9:    alu_res = src1_r & src2_r;
      4'd10:   alu_res = src2_r;
      default: alu_res = '0;
    endcase
  end

  // Mul/div launch: operand magnitudes and the sign of the selected result
  assign is_div   = md_op_r[2];
  assign is_rem   = md_op_r[1];
  assign launch   = (state == IDLE) && exe_valid && md_en_r;
  assign div_zero = is_div && (src2_r == '0);
  assign s1_neg   = (md_op_r == 3'd1 || md_op_r == 3'd2 || md_op_r == 3'd4 || md_op_r == 3'd6)
                    && src1_r[XLEN-1];
  assign s2_neg   = (md_op_r == 3'd1 || md_op_r == 3'd4 || md_op_r == 3'd6) && src2_r[XLEN-1];
  assign mag1     = fix_sign(src1_r, s1_neg);
  assign mag2     = fix_sign(src2_r, s2_neg);
  assign launch_neg = (is_div && is_rem) ? s1_neg : (s1_neg ^ s2_neg);

  // Iteration: shift-add multiply, restoring shift-subtract divide
  assign mul_sum   = prod_r + (mplier_r[0] ? mcand_r : '0);
  assign mplier_sh = mplier_r >> 1;
  assign prod_fix  = fix_sign_wide(mul_sum, neg_r);
  assign mul_res   = (md_op_r == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  assign rem_sh   = {prod_r[XLEN-1:0], mplier_r[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, mcand_r[XLEN-1:0]};
  assign q_bit    = !rem_diff[XLEN];
  assign rem_nxt  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nxt  = {mplier_r[XLEN-2:0], q_bit};

  assign last_iter = (cnt == CNT_W'(XLEN - 1));
`ifdef EXE_MD_EARLY_OUT_EN
  assign mul_done  = last_iter || (mplier_sh == '0);
`else
  assign mul_done  = last_iter;
`endif
  assign iter_done = is_div ? last_iter : mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_valid <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else if (flush) begin
      exe_valid <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else begin
      if (exe_allow_in) exe_valid <= id_to_exe_valid;
      case (state)
        IDLE: if (launch) begin
          cnt   <= '0;
          state <= div_zero ? DONE : BUSY;
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (iter_done) state <= DONE;
        end
        DONE: if (mem_allow_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Payload and mul/div datapath carry no reset
  always_ff @(posedge clk) begin
    if (exe_allow_in && id_to_exe_valid) begin
      pc_r     <= in_pc;
      src1_r   <= in_src1;
      src2_r   <= in_src2;
      alu_op_r <= in_alu_op;
      md_en_r  <= in_md_en;
      md_op_r  <= in_md_op;
      rd_r     <= in_rd;
      wen_r    <= in_wen;
    end
    if (launch) begin
      prod_r <= '0;
      neg_r  <= launch_neg;
      if (is_div) begin
        mcand_r  <= {{XLEN{1'b0}}, mag2};
        mplier_r <= mag1;
      end else begin
        mcand_r  <= {{XLEN{1'b0}}, mag1};
        mplier_r <= mag2;
      end
      if (div_zero) md_res_r <= is_rem ? src1_r : '1;
    end else if (state == BUSY) begin
      if (is_div) begin
        prod_r   <= {{XLEN{1'b0}}, rem_nxt};
        mplier_r <= quo_nxt;
        if (last_iter) md_res_r <= fix_sign(is_rem ? rem_nxt : quo_nxt, neg_r);
      end else begin
        prod_r   <= mul_sum;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_sh;
        if (mul_done) md_res_r <= mul_res;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_md.sv
// Randomised self-checking bench for exe_stage_md (XLEN=32) against a plain-arithmetic reference model.
module tb_exe_stage_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_to_exe_valid = 1'b0;
  logic        exe_allow_in;
  logic        mem_allow_in = 1'b1;
  logic        exe_to_mem_valid;
  logic        flush = 1'b0;
  logic [31:0] in_pc = '0, in_src1 = '0, in_src2 = '0;
  logic [3:0]  in_alu_op = '0;
  logic        in_md_en = 1'b0;
  logic [2:0]  in_md_op = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic [31:0] out_pc, out_result;
  logic [4:0]  out_rd;
  logic        out_wen, exe_busy, exe_fwd_valid;

  int checks = 0;
  int errors = 0;

  exe_stage_md #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_to_exe_valid(id_to_exe_valid), .exe_allow_in(exe_allow_in),
    .mem_allow_in(mem_allow_in), .exe_to_mem_valid(exe_to_mem_valid),
    .flush(flush),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2),
    .in_alu_op(in_alu_op), .in_md_en(in_md_en), .in_md_op(in_md_op),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_pc(out_pc), .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .exe_busy(exe_busy), .exe_fwd_valid(exe_fwd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    ref_alu = a + b;
      4'd1:    ref_alu = a - b;
      4'd2:    ref_alu = a << b[4:0];
      4'd3:    ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    ref_alu = (a < b) ? 32'd1 : 32'd0;
      4'd5:    ref_alu = a ^ b;
      4'd6:    ref_alu = a >> b[4:0];
      4'd7:    ref_alu = $signed(a) >>> b[4:0];
      4'd8:    ref_alu = a | b;
      4'd9:    ref_alu = a & b;
      4'd10:   ref_alu = b;
      default: ref_alu = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ref_md = '0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; ref_md = p[31:0]; end
      3'd1: begin p = sa * sb; ref_md = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); ref_md = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; ref_md = p[63:32]; end
      3'd4: if (b == 0) ref_md = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = a;
            else begin q = sa / sb; ref_md = q[31:0]; end
      3'd5: ref_md = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) ref_md = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = 0;
            else begin q = sa % sb; ref_md = q[31:0]; end
      3'd7: ref_md = (b == 0) ? a : a % b;
      default: ref_md = '0;
    endcase
  endfunction

  // Cycles from the capture edge to the first cycle exe_to_mem_valid is seen high
  function automatic int exp_lat(input logic md, input logic [2:0] op, input logic [31:0] b);
`ifdef EXE_MD_EARLY_OUT_EN
    logic [31:0] m;
    int top;
`endif
    if (!md) return 0;
    if (op[2]) return (b == 0) ? 1 : 33;
`ifdef EXE_MD_EARLY_OUT_EN
    m = (op == 3'd1 && b[31]) ? -b : b;
    top = 1;
    for (int i = 0; i < 32; i++) if (m[i]) top = i + 1;
    return 1 + top;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom % 7)
      0: pick_val = 32'd0;
      1: pick_val = 32'd1;
      2: pick_val = 32'hFFFF_FFFF;
      3: pick_val = 32'h8000_0000;
      4: pick_val = $urandom % 64;
      5: pick_val = -($urandom % 64);
      default: pick_val = $urandom;
    endcase
  endfunction

  task automatic start_op(input logic md, input logic [2:0] mop, input logic [3:0] aop,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic wen, input logic [31:0] pc);
    @(negedge clk);
    in_md_en = md; in_md_op = mop; in_alu_op = aop;
    in_src1 = a; in_src2 = b; in_rd = rd; in_wen = wen; in_pc = pc;
    mem_allow_in = 1'b1;
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    id_to_exe_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic to);
    lat = 0;
    to = 1'b0;
    while (!exe_to_mem_valid) begin
      if (lat >= 200) begin to = 1'b1; break; end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exe_allow_in !== 1'b1) begin
      errors++; $display("FAIL reset_allow_in got=%b exp=1", exe_allow_in);
    end
    checks++;
    if ({exe_to_mem_valid, exe_busy, exe_fwd_valid, out_wen} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {exe_to_mem_valid, exe_busy, exe_fwd_valid, out_wen});
    end
    checks++;
    if ({out_pc, out_result, out_rd} !== 69'd0) begin
      errors++; $display("FAIL reset_data got pc=%h res=%h rd=%h exp=0", out_pc, out_result, out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [3:0]  op;
    logic [31:0] a, b, pc, exp;
    logic [4:0]  rd;
    logic        wen, to, busy0;
    int          lat;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin op = 4'd0; a = 32'd5; b = 32'd7; end
      else begin op = 4'($urandom % 11); a = pick_val(); b = pick_val(); end
      rd = 5'($urandom); wen = 1'($urandom); pc = $urandom;
      exp = ref_alu(op, a, b);
      start_op(1'b0, 3'd0, op, a, b, rd, wen, pc);
      busy0 = exe_busy;
      wait_valid(lat, to);
      checks++;
      if (to || lat != 0 || busy0 !== 1'b0) begin
        errors++; $display("FAIL alu_timing op=%0d got lat=%0d busy=%b exp lat=0 busy=0", op, lat, busy0);
      end
      checks++;
      if (out_result !== exp) begin
        errors++; $display("FAIL alu_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, out_result, exp);
      end
      checks++;
      if (out_rd !== rd || out_pc !== pc || out_wen !== wen || exe_fwd_valid !== wen) begin
        errors++; $display("FAIL alu_payload got rd=%h pc=%h wen=%b fwd=%b exp rd=%h pc=%h wen=%b",
                           out_rd, out_pc, out_wen, exe_fwd_valid, rd, pc, wen);
      end
    end
  endtask

  task automatic test_mul_directed();
    logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd3};
    logic [31:0] exps [3] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE};
    logic        to, busy0;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, ops[i], 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h100);
      busy0 = exe_busy;
      wait_valid(lat, to);
      checks++;
      if (to || lat != 33 || busy0 !== 1'b1) begin
        errors++; $display("FAIL mul_ones_lat op=%0d got lat=%0d busy=%b exp lat=33 busy=1", ops[i], lat, busy0);
      end
      checks++;
      if (out_result !== exps[i]) begin
        errors++; $display("FAIL mul_ones_res op=%0d got=%h exp=%h", ops[i], out_result, exps[i]);
      end
    end
  endtask

  task automatic test_div_directed();
    logic [2:0]  ops [6]  = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [6]  = '{-32'sd7, -32'sd7, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] bs  [6]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exps [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
    int          lats [6] = '{33, 33, 33, 33, 1, 1};
    logic        to;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      start_op(1'b1, ops[i], 4'd0, as[i], bs[i], 5'd9, 1'b1, 32'h200);
      wait_valid(lat, to);
      checks++;
      if (to || lat != lats[i]) begin
        errors++; $display("FAIL div_lat op=%0d got=%0d exp=%0d", ops[i], lat, lats[i]);
      end
      checks++;
      if (out_result !== exps[i]) begin
        errors++; $display("FAIL div_res op=%0d a=%h b=%h got=%h exp=%h", ops[i], as[i], bs[i], out_result, exps[i]);
      end
    end
  endtask

  task automatic test_md_random();
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic        to;
    int          lat, elat;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom % 8); a = pick_val(); b = pick_val();
      exp = ref_md(op, a, b);
      elat = exp_lat(1'b1, op, b);
      start_op(1'b1, op, 4'd0, a, b, 5'($urandom), 1'b1, $urandom);
      wait_valid(lat, to);
      checks++;
      if (to || lat != elat) begin
        errors++; $display("FAIL md_rand_lat op=%0d b=%h got=%0d exp=%0d", op, b, lat, elat);
      end
      checks++;
      if (out_result !== exp) begin
        errors++; $display("FAIL md_rand_res op=%0d a=%h b=%h got=%h exp=%h", op, a, b, out_result, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp, held, alu_exp;
    logic        to;
    int          lat;
    a = $urandom; b = $urandom;
    exp = ref_md(3'd0, a, b);
    alu_exp = ref_alu(4'd1, 32'd100, 32'd42);
    start_op(1'b1, 3'd0, 4'd0, a, b, 5'd7, 1'b1, 32'h300);
    mem_allow_in = 1'b0;
    wait_valid(lat, to);
    held = out_result;
    checks++;
    if (to || held !== exp) begin
      errors++; $display("FAIL bp_result got=%h exp=%h timeout=%b", held, exp, to);
    end
    in_md_en = 1'b0; in_alu_op = 4'd1; in_src1 = 32'd100; in_src2 = 32'd42;
    in_rd = 5'd11; in_pc = 32'h304;
    id_to_exe_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_result !== held || exe_allow_in !== 1'b0 || exe_to_mem_valid !== 1'b1 || out_rd !== 5'd7) begin
        errors++; $display("FAIL bp_hold cyc=%0d got res=%h allow=%b vld=%b rd=%0d exp res=%h allow=0 vld=1 rd=7",
                           i, out_result, exe_allow_in, exe_to_mem_valid, out_rd, held);
      end
    end
    mem_allow_in = 1'b1;
    #1;
    checks++;
    if (exe_allow_in !== 1'b1) begin
      errors++; $display("FAIL bp_release_allow got=%b exp=1", exe_allow_in);
    end
    @(posedge clk);
    @(negedge clk);
    id_to_exe_valid = 1'b0;
    checks++;
    if (exe_to_mem_valid !== 1'b1 || out_result !== alu_exp || out_rd !== 5'd11) begin
      errors++; $display("FAIL bp_handoff got vld=%b res=%h rd=%0d exp vld=1 res=%h rd=11",
                         exe_to_mem_valid, out_result, out_rd, alu_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_res[$];
    logic [4:0]  q_rd[$];
    logic [31:0] cur_res, a, b;
    logic [4:0]  cur_rd;
    logic        pending, md;
    logic [2:0]  mop;
    logic [3:0]  aop;
    int          issued, retired, cyc;
    localparam int N = 24;
    issued = 0; retired = 0; cyc = 0; pending = 1'b0;
    cur_res = '0; cur_rd = '0;
    while (retired < N && cyc < 4000) begin
      @(negedge clk);
      if (!pending) id_to_exe_valid = 1'b0;
      mem_allow_in = ($urandom % 4) != 0;
      if (!pending && issued < N && ($urandom % 3) != 0) begin
        md = ($urandom % 3) == 0;
        mop = 3'($urandom % 8); aop = 4'($urandom % 11);
        a = pick_val(); b = pick_val();
        cur_res = md ? ref_md(mop, a, b) : ref_alu(aop, a, b);
        cur_rd = 5'($urandom);
        in_md_en = md; in_md_op = mop; in_alu_op = aop; in_src1 = a; in_src2 = b;
        in_rd = cur_rd; in_wen = 1'b1; in_pc = $urandom;
        id_to_exe_valid = 1'b1;
        pending = 1'b1;
      end
      #1;
      if (exe_to_mem_valid && mem_allow_in) begin
        checks++;
        if (q_res.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got res=%h exp=none", out_result);
        end else begin
          if (out_result !== q_res[0] || out_rd !== q_rd[0]) begin
            errors++; $display("FAIL b2b_result idx=%0d got res=%h rd=%0d exp res=%h rd=%0d",
                               retired, out_result, out_rd, q_res[0], q_rd[0]);
          end
          void'(q_res.pop_front());
          void'(q_rd.pop_front());
        end
        retired++;
      end
      if (id_to_exe_valid && exe_allow_in) begin
        q_res.push_back(cur_res);
        q_rd.push_back(cur_rd);
        issued++;
        pending = 1'b0;
      end
      cyc++;
    end
    mem_allow_in = 1'b1;
    checks++;
    if (retired != N) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", retired, N);
    end
    @(negedge clk);
    id_to_exe_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] exp;
    logic        to;
    int          lat, seen;
    start_op(1'b1, 3'd5, 4'd0, 32'd1000, 32'd7, 5'd4, 1'b1, 32'h400);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (exe_to_mem_valid !== 1'b0 || exe_busy !== 1'b0 || exe_allow_in !== 1'b1 || out_wen !== 1'b0) begin
      errors++; $display("FAIL flush_kill got vld=%b busy=%b allow=%b wen=%b exp 0 0 1 0",
                         exe_to_mem_valid, exe_busy, exe_allow_in, out_wen);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (exe_to_mem_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_ghost got=%0d exp=0", seen);
    end
    exp = ref_md(3'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    start_op(1'b1, 3'd3, 4'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'h404);
    wait_valid(lat, to);
    checks++;
    if (to || lat != 33 || out_result !== exp) begin
      errors++; $display("FAIL flush_relaunch got lat=%0d res=%h exp lat=33 res=%h", lat, out_result, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    logic        to;
    int          lat;
    start_op(1'b1, 3'd4, 4'd0, 32'd12345, -32'sd17, 5'd6, 1'b1, 32'h500);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({exe_to_mem_valid, exe_busy, exe_fwd_valid, out_wen} !== 4'b0 || exe_allow_in !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ctrl got vld=%b busy=%b fwd=%b wen=%b allow=%b exp 0 0 0 0 1",
                         exe_to_mem_valid, exe_busy, exe_fwd_valid, out_wen, exe_allow_in);
    end
    checks++;
    if ({out_pc, out_result, out_rd} !== 69'd0) begin
      errors++; $display("FAIL rst_mid_data got pc=%h res=%h rd=%h exp=0", out_pc, out_result, out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = ref_md(3'd6, 32'd12345, -32'sd17);
    start_op(1'b1, 3'd6, 4'd0, 32'd12345, -32'sd17, 5'd6, 1'b1, 32'h504);
    wait_valid(lat, to);
    checks++;
    if (to || lat != 33 || out_result !== exp) begin
      errors++; $display("FAIL rst_mid_after got lat=%0d res=%h exp lat=33 res=%h", lat, out_result, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul_directed();
    test_div_directed();
    test_md_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
